control_word_executor: RTL and testbench

- Consumer end of the 55-bit control word produced by the instruction decoders.
- Accepts one control word per valid/ready handshake and splits it into its fields.
- Owns the 16x16 register file and the program counter. Drives the external ALU and runs multi-cycle data memory / stack transfers.
- Retires each word with a one-cycle pulse.

---
 rtl/control_word_pkg.sv | 59 +++++
 rtl/flow_regfile.sv | 44 ++++
 rtl/control_word_executor.sv | 208 ++++++++++++++++++++
 tb/tb_control_word_executor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_word_pkg.sv
// Shared definitions for the 55-bit control word.
// The decoders that produce the word and the executor that consumes it both
// import this package.
package control_word_pkg;

   localparam int CW_W = 55;

   // Field offsets (LSB position) and widths, MSB first in the word
   localparam int PC_INC_BIT    = 54;
   localparam int ALU_OP_LSB    = 50;
   localparam int ALU_OP_W      = 4;
   localparam int A_ALT_LSB     = 34;
   localparam int B_ALT_LSB     = 18;
   localparam int ALT_W         = 16;
   localparam int A_SEL_LSB     = 14;
   localparam int B_SEL_LSB     = 10;
   localparam int SEL_W         = 4;
   localparam int A_SRC_BIT     = 9;
   localparam int B_SRC_BIT     = 8;
   localparam int OUT_SEL_LSB   = 4;
   localparam int LOAD_SRC_LSB  = 2;
   localparam int LOAD_SRC_W    = 2;
   localparam int STORE_MEM_BIT = 1;
   localparam int STORE_STK_BIT = 0;

   // load_src encodings. Any value with bit 1 set is a store (LS_STORE
   // stands for the whole 2'b1x group), so decode it with ls_is_store().
   localparam logic [1:0] LS_ALU   = 2'b00;
   localparam logic [1:0] LS_MEM   = 2'b01;
   localparam logic [1:0] LS_STORE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2,
      MEM  = 2'd3
   } cwe_state_e;

   // Packed in the same order as the word, so a plain cast splits it
   typedef struct packed {
      logic        pc_inc;
      logic [3:0]  alu_op;
      logic [15:0] a_altern;
      logic [15:0] b_altern;
      logic [3:0]  a_sel;
      logic [3:0]  b_sel;
      logic        a_src;
      logic        b_src;
      logic [3:0]  out_sel;
      logic [1:0]  load_src;
      logic        store_mem;
      logic        store_stk;
   } cw_fields_t;

   function automatic logic ls_is_store(input logic [1:0] ls);
      return ls[1];
   endfunction

endpackage

// File: rtl/flow_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// synchronous active-low clear of every entry.
module flow_regfile #(
   parameter int  DATA_W = 16,
   parameter int  NREGS  = 16,
   localparam int SEL_W  = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [SEL_W-1:0]  wsel,
   input  logic [DATA_W-1:0] wdata,
   input  logic [SEL_W-1:0]  rsel_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [SEL_W-1:0]  rsel_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   // Next register contents: only the addressed entry changes on a write
   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[wsel] = wdata;
      end
   end

   // Storage with synchronous clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata_a = regs_q[rsel_a];
   assign rdata_b = regs_q[rsel_b];

endmodule

// File: rtl/control_word_executor.sv
// Control word executor: accepts one control word per valid/ready handshake,
// drives the external ALU, runs data-memory / stack transfers, owns the
// register file and program counter, and pulses retire once per word.
// Optional build macro CWE_RETIRE_COUNT_EN adds a 32-bit wrapping
// retire_count output.
//
// Handshake: a word is accepted on a rising clk edge where cw_valid and
// cw_ready are both high; cw_ready is high only in IDLE, so cw_valid while
// busy is simply not seen. mem_req is held, with all memory outputs stable,
// until the edge where mem_ack is high (or the timeout expires).
module control_word_executor
   import control_word_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int NREGS       = 16,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [CW_W-1:0]   cw,
   input  logic              cw_valid,
   output logic              cw_ready,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_stk,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] pc,
   output logic              retire,
`ifdef CWE_RETIRE_COUNT_EN
   output logic [31:0]       retire_count,
`endif
   output logic              mem_err
);

   // Timeout counter counts completed MEM cycles without an ack
   localparam int CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

   cwe_state_e        state_q, state_d;
   cw_fields_t        cw_q, cw_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_err_q, mem_err_d;

   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata;
   logic [3:0]        rf_rsel_a;
   logic [DATA_W-1:0] rf_rdata_a;
   logic [DATA_W-1:0] rf_rdata_b;

   // Port A serves operand A in EXEC and R[out_sel] (store data) otherwise.
   // Nothing writes the register file during MEM, so R[out_sel] read here
   // equals the value sampled on entry for the whole transfer.
   assign rf_rsel_a = (state_q == EXEC) ? cw_q.a_sel : cw_q.out_sel;

   flow_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (rf_we),
      .wsel    (cw_q.out_sel),
      .wdata   (rf_wdata),
      .rsel_a  (rf_rsel_a),
      .rdata_a (rf_rdata_a),
      .rsel_b  (cw_q.b_sel),
      .rdata_b (rf_rdata_b)
   );

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cw_q      <= '0;
         result_q  <= '0;
         pc_q      <= '0;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cw_q      <= cw_d;
         result_q  <= result_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Next state, register-file write and pc update
   always_comb begin
      state_d   = state_q;
      cw_d      = cw_q;
      result_d  = result_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      mem_err_d = 1'b0;
      rf_we     = 1'b0;
      rf_wdata  = result_q;
      case (state_q)
         IDLE: begin
            if (cw_valid) begin
               cw_d    = cw_fields_t'(cw);
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_result;
            cnt_d    = '0;
            if (cw_q.load_src == LS_MEM) begin
               state_d = MEM;
            end else if (ls_is_store(cw_q.load_src) &&
                         (cw_q.store_mem || cw_q.store_stk)) begin
               state_d = MEM;
            end else begin
               // ALU word, or a store with neither target bit (no-op)
               state_d = WB;
            end
         end
         MEM: begin
            if (mem_ack) begin
               if (cw_q.load_src == LS_MEM) begin
                  rf_we    = 1'b1;
                  rf_wdata = mem_rdata;
               end
               state_d = WB;
            end else if ((MEM_TIMEOUT > 0) && (cnt_q == CNT_W'(TO_LAST))) begin
               mem_err_d = 1'b1;
               state_d   = WB;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WB: begin
            if (cw_q.load_src == LS_ALU) begin
               rf_we    = 1'b1;
               rf_wdata = result_q;
            end
            pc_d    = pc_q + DATA_W'(cw_q.pc_inc);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      cw_ready  = 1'b0;
      alu_op    = '0;
      alu_a     = '0;
      alu_b     = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_stk   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      retire    = 1'b0;
      case (state_q)
         IDLE: cw_ready = 1'b1;
         EXEC: begin
            alu_op = cw_q.alu_op;
            alu_a  = cw_q.a_src ? cw_q.a_altern : rf_rdata_a;
            alu_b  = cw_q.b_src ? cw_q.b_altern : rf_rdata_b;
         end
         MEM: begin
            mem_req   = 1'b1;
            mem_we    = ls_is_store(cw_q.load_src);
            mem_stk   = ls_is_store(cw_q.load_src) & cw_q.store_stk;
            mem_addr  = result_q;
            mem_wdata = rf_rdata_a;
         end
         WB:      retire = 1'b1;
         default: cw_ready = 1'b0;
      endcase
   end

   assign pc      = pc_q;
   assign mem_err = mem_err_q;

`ifdef CWE_RETIRE_COUNT_EN
   logic [31:0] retire_count_q, retire_count_d;

   // Count every retire pulse, wrapping at 2^32
   always_comb begin
      retire_count_d = retire_count_q + 32'(retire);
   end

   // Retire counter register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         retire_count_q <= '0;
      end else begin
         retire_count_q <= retire_count_d;
      end
   end

   assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_control_word_executor.sv
// Bench for control_word_executor with MEM_TIMEOUT = 4.
// Reference model: register array, pc and a small ALU, updated per word from
// the field layout of the control word.
module tb_control_word_executor;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [54:0] cw = '0;
   logic        cw_valid = 1'b0;
   logic        cw_ready;
   logic [3:0]  alu_op;
   logic [15:0] alu_a, alu_b, alu_result;
   logic        mem_req, mem_we, mem_stk;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [15:0] pc;
   logic        retire, mem_err;
`ifdef CWE_RETIRE_COUNT_EN
   logic [31:0] retire_count;
`endif

   int errors = 0;
   int checks = 0;

   logic [15:0] m_regs [16];
   logic [15:0] m_pc;
   int          m_retires;

   always #5 clk = ~clk;

   // External ALU seen by the DUT
   function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      case (op)
         4'd0:    return a;
         4'd1:    return b;
         4'd2:    return a + b;
         4'd3:    return a - b;
         4'd4:    return a & b;
         4'd5:    return a | b;
         4'd6:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   assign alu_result = alu_f(alu_op, alu_a, alu_b);

   control_word_executor #(
      .DATA_W      (16),
      .NREGS       (16),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cw         (cw),
      .cw_valid   (cw_valid),
      .cw_ready   (cw_ready),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_stk    (mem_stk),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .pc         (pc),
      .retire     (retire),
`ifdef CWE_RETIRE_COUNT_EN
      .retire_count (retire_count),
`endif
      .mem_err    (mem_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [54:0] mk(input logic inc, input logic [3:0] op,
                                      input logic [15:0] aalt, input logic [15:0] balt,
                                      input logic [3:0] asel, input logic [3:0] bsel,
                                      input logic asrc, input logic bsrc,
                                      input logic [3:0] osel, input logic [1:0] ls,
                                      input logic sm, input logic ss);
      return {inc, op, aalt, balt, asel, bsel, asrc, bsrc, osel, ls, sm, ss};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_pc      = '0;
      m_retires = 0;
   endtask

   // Runs one word from an IDLE negedge to the next IDLE negedge.
   // ack_at: MEM cycle (1-based) carrying mem_ack; 0 or > TO means no ack.
   task automatic run_word(input logic [54:0] w, input int ack_at,
                           input logic [15:0] rd, input bit hold);
      logic        inc, asrc, bsrc, sm, ss, goes_mem, timed_out, acked;
      logic [3:0]  op, asel, bsel, osel;
      logic [1:0]  ls;
      logic [15:0] aalt, balt, exp_a, exp_b, res;
      inc  = w[54];    op   = w[53:50]; aalt = w[49:34]; balt = w[33:18];
      asel = w[17:14]; bsel = w[13:10]; asrc = w[9];     bsrc = w[8];
      osel = w[7:4];   ls   = w[3:2];   sm   = w[1];     ss   = w[0];
      exp_a    = asrc ? aalt : m_regs[asel];
      exp_b    = bsrc ? balt : m_regs[bsel];
      res      = alu_f(op, exp_a, exp_b);
      goes_mem = (ls == 2'b01) || (ls[1] && (sm || ss));

      chk("ready_idle", 32'(cw_ready), 32'd1);
      cw       = w;
      cw_valid = 1'b1;
      @(negedge clk);
      if (!hold) cw_valid = 1'b0;
      chk("ready_exec", 32'(cw_ready), 32'd0);
      chk("alu_op", 32'(alu_op), 32'(op));
      chk("alu_a", 32'(alu_a), 32'(exp_a));
      chk("alu_b", 32'(alu_b), 32'(exp_b));
      chk("req_exec", 32'(mem_req), 32'd0);

      timed_out = 1'b0;
      acked     = 1'b0;
      if (goes_mem) begin
         for (int k = 1; k <= TO && !acked; k++) begin
            @(negedge clk);
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("mem_we", 32'(mem_we), 32'(ls[1]));
            chk("mem_stk", 32'(mem_stk), 32'(ls[1] & ss));
            chk("mem_addr", 32'(mem_addr), 32'(res));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_regs[osel]));
            chk("ready_mem", 32'(cw_ready), 32'd0);
            if (k == ack_at) begin
               mem_ack   = 1'b1;
               mem_rdata = rd;
               acked     = 1'b1;
            end
         end
         timed_out = !acked;
      end

      @(negedge clk);
      mem_ack = 1'b0;
      chk("retire", 32'(retire), 32'd1);
      chk("mem_err", 32'(mem_err), 32'(timed_out));
      chk("req_wb", 32'(mem_req), 32'd0);
      chk("ready_wb", 32'(cw_ready), 32'd0);
      if (ls == 2'b00) m_regs[osel] = res;
      else if (ls == 2'b01 && !timed_out) m_regs[osel] = rd;
      m_pc = m_pc + 16'(inc);
      m_retires++;

      @(negedge clk);
      cw_valid = 1'b0;
      chk("retire_clr", 32'(retire), 32'd0);
      chk("mem_err_clr", 32'(mem_err), 32'd0);
      chk("pc", 32'(pc), 32'(m_pc));
      chk("ready_after", 32'(cw_ready), 32'd1);
   endtask

   // Reads R[i] back through operand A of a no-op store word
   task automatic probe_reg(input logic [3:0] i);
      run_word(mk(1'b0, 4'd0, 16'h0, 16'h0, i, 4'd0, 1'b0, 1'b0, 4'd0, 2'b10, 1'b0, 1'b0),
               0, 16'h0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] r;
      model_reset();

      // Reset state
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(cw_ready), 32'd1);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      chk("rst_err", 32'(mem_err), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      reset_n = 1'b1;

      // ALU word: A from a_altern, op pass-A, into R3
      run_word(mk(1'b1, 4'd0, 16'h1234, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd3, 2'b00, 1'b0, 1'b0),
               0, 16'h0, 1'b0);
      probe_reg(4'd3);

      // Load: R2 = 0x0040, then read address R2, ack in third cycle
      run_word(mk(1'b1, 4'd0, 16'h0040, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2, 2'b00, 1'b0, 1'b0),
               0, 16'h0, 1'b0);
      run_word(mk(1'b1, 4'd0, 16'h0, 16'h0, 4'd2, 4'd0, 1'b0, 1'b0, 4'd7, 2'b01, 1'b0, 1'b0),
               3, 16'hBEEF, 1'b0);
      probe_reg(4'd7);

      // Stack store of R5 = 0x00AA, ack on first cycle
      run_word(mk(1'b1, 4'd0, 16'h00AA, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd5, 2'b00, 1'b0, 1'b0),
               0, 16'h0, 1'b0);
      run_word(mk(1'b1, 4'd0, 16'h0100, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd5, 2'b11, 1'b0, 1'b1),
               1, 16'h5555, 1'b0);
      probe_reg(4'd5);

      // Data-memory store from R7
      run_word(mk(1'b1, 4'd2, 16'h0010, 16'h0, 4'd0, 4'd3, 1'b1, 1'b0, 4'd7, 2'b10, 1'b1, 1'b0),
               2, 16'h0, 1'b0);

      // Timeout: load that is never acked
      run_word(mk(1'b1, 4'd0, 16'h0200, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd9, 2'b01, 1'b0, 1'b0),
               0, 16'h1111, 1'b0);
      probe_reg(4'd9);

      // Back-pressure: cw_valid held high across a MEM transfer
      run_word(mk(1'b1, 4'd0, 16'h0300, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd10, 2'b01, 1'b0, 1'b0),
               2, 16'hCAFE, 1'b1);
      probe_reg(4'd10);

      // Register operands and b_altern through the adder
      run_word(mk(1'b1, 4'd2, 16'h0, 16'h0101, 4'd3, 4'd0, 1'b0, 1'b1, 4'd4, 2'b00, 1'b0, 1'b0),
               0, 16'h0, 1'b0);
      run_word(mk(1'b1, 4'd3, 16'h0, 16'h0, 4'd4, 4'd7, 1'b0, 1'b0, 4'd11, 2'b00, 1'b0, 1'b0),
               0, 16'h0, 1'b0);
      probe_reg(4'd11);

      // pc wrap: preload pc to 0xFFFF
      force dut.pc_q = 16'hFFFF;
      @(posedge clk);
      #1 release dut.pc_q;
      @(negedge clk);
      m_pc = 16'hFFFF;
      chk("pc_preload", 32'(pc), 32'hFFFF);
      run_word(mk(1'b1, 4'd0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd12, 2'b00, 1'b0, 1'b0),
               0, 16'h0, 1'b0);
      run_word(mk(1'b0, 4'd0, 16'h7, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd12, 2'b00, 1'b0, 1'b0),
               0, 16'h0, 1'b0);

      // Randomized words
      for (int n = 0; n < 60; n++) begin
         r = {$urandom(), $urandom()};
         run_word(r[54:0], int'($urandom_range(0, 5)), 16'($urandom()),
                  1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 16; i++) probe_reg(4'(i));

      // Reset in the middle of a load; a late ack must be ignored
      chk("ready_pre_rst", 32'(cw_ready), 32'd1);
      cw       = mk(1'b1, 4'd0, 16'h0400, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd6, 2'b01, 1'b0, 1'b0);
      cw_valid = 1'b1;
      @(negedge clk);
      cw_valid = 1'b0;
      @(negedge clk);
      chk("req_before_rst", 32'(mem_req), 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      model_reset();
      chk("rst_mid_req", 32'(mem_req), 32'd0);
      chk("rst_mid_pc", 32'(pc), 32'd0);
      chk("rst_mid_ready", 32'(cw_ready), 32'd1);
      reset_n   = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("late_ack_retire", 32'(retire), 32'd0);
      chk("late_ack_req", 32'(mem_req), 32'd0);
      chk("late_ack_ready", 32'(cw_ready), 32'd1);
      probe_reg(4'd6);
      probe_reg(4'd3);
      probe_reg(4'd5);

`ifdef CWE_RETIRE_COUNT_EN
      chk("retire_count", retire_count, 32'(m_retires));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
